// File: rtl/gate_sweep_checker.sv
// Exhaustive sweep checker for an external N-input gate: drives every input vector,
// compares the gate output with the selected function, and reports mismatches and the first failing vector.
module gate_sweep_checker #(
  parameter int N     = 2,
  parameter int ERR_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [1:0]       MODE,
  input  logic             Y_IN,
  output logic [N-1:0]     A_OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_COUNT,
  output logic [N-1:0]     FIRST_FAIL,
  output logic             FAIL_VALID
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    CHECK  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [N-1:0]     A_ONES  = {N{1'b1}};
  localparam logic [N-1:0]     A_ZERO  = {N{1'b0}};
  localparam logic [N-1:0]     A_INC   = N'(1'b1);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ZERO = {ERR_W{1'b0}};
  localparam logic [ERR_W-1:0] ERR_INC = ERR_W'(1'b1);

  state_t           state_r, state_s;
  logic [1:0]       mode_r, mode_s;
  logic [N-1:0]     a_r, a_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             pass_r, pass_s;
  logic [ERR_W-1:0] err_r, err_s;
  logic [N-1:0]     ff_r, ff_s;
  logic             fv_r, fv_s;
  logic             mismatch_s;

  function automatic logic expected_bit(input logic [N-1:0] a, input logic [1:0] m);
    logic r;
    case (m)
      2'b00:   r = &a;
      2'b01:   r = |a;
      2'b10:   r = ^a;
      2'b11:   r = ~&a;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Next-state and next-output computation; every register holds unless a state acts on it.
  always_comb begin
    state_s    = state_r;
    mode_s     = mode_r;
    a_s        = a_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    pass_s     = pass_r;
    err_s      = err_r;
    ff_s       = ff_r;
    fv_s       = fv_r;
    mismatch_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (START) begin
          mode_s  = MODE;
          err_s   = ERR_ZERO;
          ff_s    = A_ZERO;
          fv_s    = 1'b0;
          pass_s  = 1'b0;
          a_s     = A_ZERO;
          busy_s  = 1'b1;
          state_s = DRIVE;
        end else begin
          state_s = IDLE;
        end
      end
      DRIVE: begin
        state_s = CHECK;
      end
      CHECK: begin
        mismatch_s = (Y_IN != expected_bit(a_r, mode_r));
        if (mismatch_s) begin
          if (err_r != ERR_MAX) begin
            err_s = err_r + ERR_INC;
          end else begin
            err_s = err_r;
          end
          if (!fv_r) begin
            ff_s = a_r;
            fv_s = 1'b1;
          end else begin
            ff_s = ff_r;
          end
        end else begin
          err_s = err_r;
        end
        // PASS uses the updated count so the final vector's result is included.
        if (a_r == A_ONES) begin
          state_s = FINISH;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          pass_s  = (err_s == ERR_ZERO);
        end else begin
          a_s     = a_r + A_INC;
          state_s = DRIVE;
        end
      end
      FINISH: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= IDLE;
      mode_r  <= 2'b00;
      a_r     <= A_ZERO;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      err_r   <= ERR_ZERO;
      ff_r    <= A_ZERO;
      fv_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      mode_r  <= mode_s;
      a_r     <= a_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      pass_r  <= pass_s;
      err_r   <= err_s;
      ff_r    <= ff_s;
      fv_r    <= fv_s;
    end
  end

  assign A_OUT      = a_r;
  assign BUSY       = busy_r;
  assign DONE       = done_r;
  assign PASS       = pass_r;
  assign ERR_COUNT  = err_r;
  assign FIRST_FAIL = ff_r;
  assign FAIL_VALID = fv_r;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboard bench for gate_sweep_checker: three instances (N=2, N=3, N=3 with a 2-bit counter)
// each driven by a behavioural gate; DONE-triggered monitors pop hand-computed expectations.
module tb_gate_sweep_checker;

  localparam int G_AND = 0, G_OR = 1, G_XOR = 2, G_NAND = 3, G_STUCK1 = 4;

  typedef struct {
    logic pass;
    int   err;
    int   ff;
    logic fv;
    int   done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   u2_start = -1;

  exp_t q2[$];
  exp_t q3[$];
  exp_t q3s[$];

  logic       start2 = 1'b0, start3 = 1'b0, start3s = 1'b0;
  logic [1:0] mode2 = 2'b00, mode3 = 2'b00, mode3s = 2'b00;
  int         g2 = G_AND, g3 = G_AND, g3s = G_AND;
  logic       y2, y3, y3s;

  logic [1:0] a2, ff2;
  logic [7:0] err2;
  logic       busy2, done2, pass2, fv2;
  logic [2:0] a3, ff3;
  logic [7:0] err3;
  logic       busy3, done3, pass3, fv3;
  logic [2:0] a3s, ff3s;
  logic [1:0] err3s;
  logic       busy3s, done3s, pass3s, fv3s;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic gate_eval(input int g, input logic [7:0] a, input int n);
    logic [7:0] mask;
    logic [7:0] v;
    mask = 8'((1 << n) - 1);
    v    = a & mask;
    case (g)
      G_AND:   return (v == mask);
      G_OR:    return (v != 8'd0);
      G_XOR:   return ^v;
      G_NAND:  return (v != mask);
      default: return 1'b1;
    endcase
  endfunction

  assign y2  = gate_eval(g2,  {6'd0, a2},  2);
  assign y3  = gate_eval(g3,  {5'd0, a3},  3);
  assign y3s = gate_eval(g3s, {5'd0, a3s}, 3);

  gate_sweep_checker #(.N(2), .ERR_W(8)) u2 (
    .CLK(clk), .RST_N(rst_n), .START(start2), .MODE(mode2), .Y_IN(y2),
    .A_OUT(a2), .BUSY(busy2), .DONE(done2), .PASS(pass2),
    .ERR_COUNT(err2), .FIRST_FAIL(ff2), .FAIL_VALID(fv2));

  gate_sweep_checker #(.N(3), .ERR_W(8)) u3 (
    .CLK(clk), .RST_N(rst_n), .START(start3), .MODE(mode3), .Y_IN(y3),
    .A_OUT(a3), .BUSY(busy3), .DONE(done3), .PASS(pass3),
    .ERR_COUNT(err3), .FIRST_FAIL(ff3), .FAIL_VALID(fv3));

  gate_sweep_checker #(.N(3), .ERR_W(2)) u3s (
    .CLK(clk), .RST_N(rst_n), .START(start3s), .MODE(mode3s), .Y_IN(y3s),
    .A_OUT(a3s), .BUSY(busy3s), .DONE(done3s), .PASS(pass3s),
    .ERR_COUNT(err3s), .FIRST_FAIL(ff3s), .FAIL_VALID(fv3s));

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic compare_result(input string tag, input exp_t e, input logic pass,
                                input int err, input int ff, input logic fv, input int all_ones,
                                input int a);
    chk({tag, "_done_cycle"}, cyc, e.done_cyc);
    chk({tag, "_pass"}, int'(pass), int'(e.pass));
    chk({tag, "_err_count"}, err, e.err);
    chk({tag, "_fail_valid"}, int'(fv), int'(e.fv));
    chk({tag, "_first_fail"}, ff, e.ff);
    chk({tag, "_a_out_final"}, a, all_ones);
  endtask

  // Scoreboard monitors: one per instance, triggered by the DONE pulse.
  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) chk("u2_unexpected_done", 1, 0);
      else compare_result("u2", q2.pop_front(), pass2, int'(err2), int'(ff2), fv2, 3, int'(a2));
    end
    if (done3) begin
      if (q3.size() == 0) chk("u3_unexpected_done", 1, 0);
      else compare_result("u3", q3.pop_front(), pass3, int'(err3), int'(ff3), fv3, 7, int'(a3));
    end
    if (done3s) begin
      if (q3s.size() == 0) chk("u3s_unexpected_done", 1, 0);
      else compare_result("u3s", q3s.pop_front(), pass3s, int'(err3s), int'(ff3s), fv3s, 7, int'(a3s));
    end
  end

  // Per-cycle trace of the N=2 instance relative to its START-sampling edge.
  always @(negedge clk) begin
    int e;
    if (u2_start >= 0) begin
      e = cyc - u2_start;
      if (e >= 0 && e <= 8) begin
        chk($sformatf("u2_a_out_e%0d", e), int'(a2), (e / 2 > 3) ? 3 : e / 2);
        chk($sformatf("u2_busy_e%0d", e), int'(busy2), (e < 8) ? 1 : 0);
        chk($sformatf("u2_done_e%0d", e), int'(done2), (e == 8) ? 1 : 0);
      end
    end
  end

  task automatic launch(input int dut, input logic [1:0] m, input int gate, input bit push,
                        input logic ep, input int eerr, input int eff, input logic efv,
                        output int c0);
    exp_t e;
    @(negedge clk);
    c0 = cyc;
    e.pass = ep;
    e.err = eerr;
    e.ff = eff;
    e.fv = efv;
    e.done_cyc = cyc + 1 + ((dut == 0) ? 8 : 16);
    case (dut)
      0: begin
        start2 = 1'b1; mode2 = m; g2 = gate;
        u2_start = cyc + 1;
        if (push) q2.push_back(e);
      end
      1: begin
        start3 = 1'b1; mode3 = m; g3 = gate;
        if (push) q3.push_back(e);
      end
      default: begin
        start3s = 1'b1; mode3s = m; g3s = gate;
        if (push) q3s.push_back(e);
      end
    endcase
    @(negedge clk);
    start2 = 1'b0;
    start3 = 1'b0;
    start3s = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q2.size() + q3.size() + q3s.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", q2.size() + q3.size() + q3s.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int c0;
    exp_t e;
    repeat (3) @(negedge clk);
    chk("rst_a_out", int'(a2), 0);
    chk("rst_busy", int'(busy2), 0);
    chk("rst_done", int'(done2), 0);
    chk("rst_pass", int'(pass2), 0);
    chk("rst_err", int'(err2), 0);
    chk("rst_first_fail", int'(ff2), 0);
    chk("rst_fail_valid", int'(fv2), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Correct AND gate, then an OR gate in AND mode (mismatches at 1 and 2).
    launch(0, 2'b00, G_AND, 1'b1, 1'b1, 0, 0, 1'b0, c0);
    drain();
    launch(0, 2'b00, G_OR, 1'b1, 1'b0, 2, 1, 1'b1, c0);
    drain();

    // N=3: NAND and XOR correct; XOR mode against an OR gate mismatches at 3,5,6.
    launch(1, 2'b11, G_NAND, 1'b1, 1'b1, 0, 0, 1'b0, c0);
    drain();
    launch(1, 2'b10, G_XOR, 1'b1, 1'b1, 0, 0, 1'b0, c0);
    drain();
    launch(1, 2'b10, G_OR, 1'b1, 1'b0, 3, 3, 1'b1, c0);
    drain();

    // START re-pulsed and MODE switched to OR mid-sweep must not disturb the run.
    launch(0, 2'b00, G_AND, 1'b1, 1'b1, 0, 0, 1'b0, c0);
    repeat (2) @(negedge clk);
    start2 = 1'b1;
    mode2 = 2'b01;
    @(negedge clk);
    start2 = 1'b0;
    drain();
    mode2 = 2'b00;

    // Back-to-back: START held high relaunches two cycles after DONE.
    launch(0, 2'b00, G_AND, 1'b1, 1'b1, 0, 0, 1'b0, c0);
    e.pass = 1'b1; e.err = 0; e.ff = 0; e.fv = 1'b0; e.done_cyc = c0 + 19;
    q2.push_back(e);
    start2 = 1'b1;
    while (cyc < c0 + 10) @(negedge clk);
    u2_start = c0 + 11;
    @(negedge clk);
    start2 = 1'b0;
    drain();

    // Asynchronous reset while A_OUT=2 aborts the sweep without DONE.
    launch(0, 2'b00, G_AND, 1'b0, 1'b1, 0, 0, 1'b0, c0);
    while (cyc < c0 + 5) @(negedge clk);
    u2_start = -1;
    rst_n = 1'b0;
    #1;
    chk("abort_a_out", int'(a2), 0);
    chk("abort_busy", int'(busy2), 0);
    chk("abort_done", int'(done2), 0);
    chk("abort_err", int'(err2), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    launch(0, 2'b00, G_AND, 1'b1, 1'b1, 0, 0, 1'b0, c0);
    drain();

    // Y stuck at 1 in AND mode: 7 mismatches saturate a 2-bit counter at 3.
    launch(2, 2'b00, G_STUCK1, 1'b1, 1'b0, 3, 0, 1'b1, c0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
